// File: rtl/regfile_pkg.sv
// Shared defaults and the address qualification helper for the global register bank.
package regfile_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 8;

    // An address selects real storage only when it is in range and is not a hardwired r0.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth,
                                     input logic zero_r0);
        return (addr < depth) && !(zero_r0 && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address mux, write-to-read bypass, pend lookup and optional output register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ZERO_R0  = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_REG = 0
) (
    input  logic                       clk_i,
    input  logic                       clr_ni,
    input  logic [$clog2(DEPTH)-1:0]   ra_i,
    input  logic [WIDTH-1:0]           regs_i [DEPTH],
    input  logic [DEPTH-1:0]           pend_i,
    input  logic                       we_ok_i,
    input  logic [$clog2(DEPTH)-1:0]   wa_i,
    input  logic [WIDTH-1:0]           wd_i,
    input  logic                       set_ok_i,
    input  logic [$clog2(DEPTH)-1:0]   pa_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       pend_o
);

    logic [WIDTH-1:0] data_d;
    logic             pend_d;

    // Combinational read value, with the in-flight write forwarded when enabled.
    always_comb begin
        data_d = '0;
        pend_d = 1'b0;
        if (addr_ok(32'(ra_i), DEPTH, ZERO_R0 != 0)) begin
            data_d = regs_i[ra_i];
            pend_d = pend_i[ra_i];
            // we_ok_i already implies a valid WA, so a match implies a valid RA too.
            if ((BYPASS != 0) && we_ok_i && (wa_i == ra_i)) begin
                data_d = wd_i;
                pend_d = set_ok_i && (pa_i == ra_i);
            end
        end
    end

    if (READ_REG != 0) begin : g_reg
        logic [WIDTH-1:0] data_q;
        logic             pend_q;

        // Output register: outputs in cycle n+1 reflect the read evaluated in cycle n.
        always_ff @(posedge clk_i) begin
            if (!clr_ni) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else begin
                data_q <= data_d;
                pend_q <= pend_d;
            end
        end

        assign data_o = data_q;
        assign pend_o = pend_q;
    end else begin : g_comb
        logic unused_clk;
        assign unused_clk = clk_i ^ clr_ni;
        assign data_o     = data_d;
        assign pend_o     = pend_d;
    end

endmodule

// File: rtl/global_regfile_param.sv
// Global register bank: storage, pending scoreboard and write decode, with two read ports.
module global_regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ZERO_R0  = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_REG = 0
) (
    input  logic                       Clk,
    input  logic                       Clr,
    input  logic                       WE,
    input  logic [$clog2(DEPTH)-1:0]   WA,
    input  logic [WIDTH-1:0]           WD,
    input  logic [$clog2(DEPTH)-1:0]   RA,
    input  logic [$clog2(DEPTH)-1:0]   RB,
    input  logic                       Set_pend,
    input  logic [$clog2(DEPTH)-1:0]   PA,
    output logic [WIDTH-1:0]           Aout,
    output logic [WIDTH-1:0]           Bout,
    output logic                       A_pend,
    output logic                       B_pend
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             we_ok;
    logic             set_ok;

    assign we_ok  = WE && addr_ok(32'(WA), DEPTH, ZERO_R0 != 0);
    assign set_ok = Set_pend && addr_ok(32'(PA), DEPTH, ZERO_R0 != 0);

    // Next state: reset clears everything; a write clears pend, a same-address set wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (!Clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_d[i] = '0;
            end
            pend_d = '0;
        end else begin
            if (we_ok) begin
                regs_d[WA] = WD;
                pend_d[WA] = 1'b0;
            end
            if (set_ok) begin
                pend_d[PA] = 1'b1;
            end
        end
    end

    // State register for storage and scoreboard.
    always_ff @(posedge Clk) begin
        regs_q <= regs_d;
        pend_q <= pend_d;
    end

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_R0  (ZERO_R0),
        .BYPASS   (BYPASS),
        .READ_REG (READ_REG)
    ) u_port_a (
        .clk_i    (Clk),
        .clr_ni   (Clr),
        .ra_i     (RA),
        .regs_i   (regs_q),
        .pend_i   (pend_q),
        .we_ok_i  (we_ok),
        .wa_i     (WA),
        .wd_i     (WD),
        .set_ok_i (set_ok),
        .pa_i     (PA),
        .data_o   (Aout),
        .pend_o   (A_pend)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_R0  (ZERO_R0),
        .BYPASS   (BYPASS),
        .READ_REG (READ_REG)
    ) u_port_b (
        .clk_i    (Clk),
        .clr_ni   (Clr),
        .ra_i     (RB),
        .regs_i   (regs_q),
        .pend_i   (pend_q),
        .we_ok_i  (we_ok),
        .wa_i     (WA),
        .wd_i     (WD),
        .set_ok_i (set_ok),
        .pa_i     (PA),
        .data_o   (Bout),
        .pend_o   (B_pend)
    );

endmodule

// File: tb/tb_global_regfile_param.sv
// Bench for global_regfile_param: one combinational-read and one registered-read instance
// driven by the same directed stimulus and checked against a behavioural model.
module tb_global_regfile_param;

    logic        Clk;
    logic        Clr;
    logic        WE;
    logic [2:0]  WA;
    logic [31:0] WD;
    logic [2:0]  RA;
    logic [2:0]  RB;
    logic        Set_pend;
    logic [2:0]  PA;

    logic [31:0] a0, b0, a1, b1;
    logic        ap0, bp0, ap1, bp1;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Behavioural model state
    logic [31:0] mreg [8];
    logic        mpend [8];
    logic [31:0] ea1, eb1;
    logic        eap1, ebp1;

    global_regfile_param #(
        .WIDTH(32), .DEPTH(8), .ZERO_R0(1), .BYPASS(1), .READ_REG(0)
    ) dut0 (
        .Clk(Clk), .Clr(Clr), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RB(RB),
        .Set_pend(Set_pend), .PA(PA), .Aout(a0), .Bout(b0), .A_pend(ap0), .B_pend(bp0)
    );

    global_regfile_param #(
        .WIDTH(32), .DEPTH(8), .ZERO_R0(1), .BYPASS(1), .READ_REG(1)
    ) dut1 (
        .Clk(Clk), .Clr(Clr), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RB(RB),
        .Set_pend(Set_pend), .PA(PA), .Aout(a1), .Bout(b1), .A_pend(ap1), .B_pend(bp1)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    // Value a read of address r must show right now: r0 is zero, a live write is forwarded.
    function automatic logic [31:0] m_data(input logic [2:0] r);
        if (r == 0) return 32'h0;
        if (WE && WA != 0 && WA == r) return WD;
        return mreg[r];
    endfunction

    function automatic logic m_pend(input logic [2:0] r);
        if (r == 0) return 1'b0;
        if (WE && WA != 0 && WA == r) return Set_pend && (PA == r);
        return mpend[r];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the edge; registered-read expectations capture pre-edge read values.
    always @(posedge Clk) begin
        if (!Clr) begin
            ea1 = 0; eb1 = 0; eap1 = 0; ebp1 = 0;
            for (int i = 0; i < 8; i++) begin
                mreg[i] = 0;
                mpend[i] = 0;
            end
        end else begin
            ea1 = m_data(RA); eb1 = m_data(RB);
            eap1 = m_pend(RA); ebp1 = m_pend(RB);
            if (WE && WA != 0) begin
                mreg[WA] = WD;
                mpend[WA] = 0;
            end
            if (Set_pend && PA != 0) mpend[PA] = 1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        if (checking) begin
            chk("c_aout", a0, m_data(RA));
            chk("c_bout", b0, m_data(RB));
            chk("c_apend", 32'(ap0), 32'(m_pend(RA)));
            chk("c_bpend", 32'(bp0), 32'(m_pend(RB)));
            chk("r_aout", a1, ea1);
            chk("r_bout", b1, eb1);
            chk("r_apend", 32'(ap1), 32'(eap1));
            chk("r_bpend", 32'(bp1), 32'(ebp1));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WE = 0; Set_pend = 0;
    endtask

    initial begin
        Clr = 0; WE = 0; WA = 0; WD = 0; RA = 0; RB = 0; Set_pend = 0; PA = 0;
        tick();
        checking = 1;

        // 1: reset state
        Clr = 1; RA = 3; RB = 7;
        @(negedge Clk);
        chk("t1_aout", a0, 32'h0);
        chk("t1_bpend", 32'(bp0), 32'h0);
        chk("t1_reg_aout", a1, 32'h0);
        tick();

        // 2: write r5, forwarded in the write cycle, visible afterwards
        WE = 1; WA = 5; WD = 32'hDEADBEEF; RA = 5;
        @(negedge Clk);
        chk("t2_bypass", a0, 32'hDEADBEEF);
        tick();
        idle();
        @(negedge Clk);
        chk("t2_stored", a0, 32'hDEADBEEF);
        chk("t2_reg_aout", a1, 32'hDEADBEEF);
        tick();

        // 3: writes to r0 are dropped
        WE = 1; WA = 0; WD = 32'hFFFFFFFF; RA = 0; RB = 0;
        @(negedge Clk);
        chk("t3_aout", a0, 32'h0);
        chk("t3_bout", b0, 32'h0);
        tick();
        idle(); Set_pend = 1; PA = 0;
        @(negedge Clk);
        chk("t3_reg_aout", a1, 32'h0);
        tick();
        idle();
        @(negedge Clk);
        chk("t3_r0_pend", 32'(ap0), 32'h0);
        tick();

        // 4: pending scoreboard
        Set_pend = 1; PA = 2; RA = 2;
        tick();
        idle();
        @(negedge Clk);
        chk("t4_pend_set", 32'(ap0), 32'h1);
        tick();
        WE = 1; WA = 2; WD = 32'hAAAA5555;
        @(negedge Clk);
        chk("t4_pend_fwd_clear", 32'(ap0), 32'h0);
        tick();
        idle();
        @(negedge Clk);
        chk("t4_pend_clear", 32'(ap0), 32'h0);
        chk("t4_data", a0, 32'hAAAA5555);
        tick();
        WE = 1; WA = 2; WD = 32'h00005A5A; Set_pend = 1; PA = 2;
        tick();
        idle();
        @(negedge Clk);
        chk("t4_set_wins_pend", 32'(ap0), 32'h1);
        chk("t4_set_wins_data", a0, 32'h00005A5A);
        tick();

        // 5: reset dominates a same-cycle write
        WE = 1; WA = 4; WD = 32'h12345678; Set_pend = 1; PA = 4;
        tick();
        idle(); RA = 4; RB = 2;
        @(negedge Clk);
        chk("t5_pre_data", a0, 32'h12345678);
        chk("t5_pre_pend", 32'(ap0), 32'h1);
        tick();
        Clr = 0; WE = 1; WA = 4; WD = 32'h1;
        tick();
        Clr = 1; idle();
        @(negedge Clk);
        chk("t5_data", a0, 32'h0);
        chk("t5_pend", 32'(ap0), 32'h0);
        chk("t5_r2_pend", 32'(bp0), 32'h0);
        chk("t5_reg_aout", a1, 32'h0);
        tick();

        // 6: registered read latency
        WE = 1; WA = 1; WD = 32'h11111111;
        tick();
        WA = 6; WD = 32'h66666666;
        tick();
        idle(); RA = 1;
        tick();
        RA = 6;
        @(negedge Clk);
        chk("t6_reg_old", a1, 32'h11111111);
        tick();
        @(negedge Clk);
        chk("t6_reg_new", a1, 32'h66666666);
        RA = 6; RB = 6; WE = 1; WA = 6; WD = 32'hCAFEF00D;
        tick();
        idle();
        @(negedge Clk);
        chk("t6_reg_fwd_a", a1, 32'hCAFEF00D);
        chk("t6_reg_fwd_b", b1, 32'hCAFEF00D);
        tick();

        // A few mixed vectors for the every-cycle compare
        WE = 1; WA = 3; WD = 32'h0BADF00D; Set_pend = 1; PA = 7; RA = 3; RB = 7;
        tick();
        WE = 1; WA = 7; WD = 32'h77777777; Set_pend = 1; PA = 3; RA = 7; RB = 3;
        tick();
        idle(); RA = 3; RB = 7;
        tick();
        tick();

        checking = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
